// File: rtl/code_loader.sv
`default_nettype none
// ============================================================================
// Module   : code_loader
// Brief    : Loads a length-prefixed 16-bit word stream into code memory,
//            then holds the processor in RUN until the next start.
// Revision : 1.0 - initial release
// ============================================================================
module code_loader #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        code_w_en,
  output logic [8:0]  code_addr_in,
  output logic [15:0] code_in,
  output logic        run,
  output logic        busy,
  output logic        err
);

  localparam int c_IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_RUN     = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_hi;
  logic [9:0]          r_len;
  logic [9:0]          r_cnt;
  logic [7:0]          r_data_hi;
  logic [8:0]          r_addr;
  logic [15:0]         r_code;
  logic [c_IDLE_W-1:0] r_idle;

  logic        w_xfer;
  logic        w_len_ok;
  logic        w_timeout;
  logic        w_restart;
  logic        w_last;
  logic [15:0] w_len;

  assign byte_ready   = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
  assign busy         = byte_ready || (r_state == S_WRITE);
  assign code_w_en    = (r_state == S_WRITE);
  assign run          = (r_state == S_RUN);
  assign err          = (r_state == S_ERR);
  assign code_addr_in = r_addr;
  assign code_in      = r_code;

  assign w_len     = {r_len_hi, byte_in};
  assign w_len_ok  = (w_len != 16'd0) && (w_len <= 16'd512);
  assign w_xfer    = byte_valid && byte_ready;
  assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERR));
  assign w_last    = ((r_cnt + 10'd1) == r_len);
  // The idle counter only advances while a byte is awaited, so WRITE can never time out.
  assign w_timeout = (TIMEOUT > 0) && byte_ready && !w_xfer && (r_idle == c_IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer)         w_next = S_LEN_LO;
        else if (w_timeout) w_next = S_ERR;
      end
      S_LEN_LO: begin
        if (w_xfer)         w_next = w_len_ok ? S_DATA_HI : S_ERR;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DATA_HI: begin
        if (w_xfer)         w_next = S_DATA_LO;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DATA_LO: begin
        if (w_xfer)         w_next = S_WRITE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WRITE: w_next = w_last ? S_RUN : S_DATA_HI;
      default: w_next = S_IDLE;
    endcase
  end

  // The high data byte is staged separately so code_in only changes when a WRITE begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi  <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_data_hi <= '0;
      r_addr    <= '0;
      r_code    <= '0;
      r_idle    <= '0;
    end else begin
      if (w_restart) begin
        r_cnt  <= '0;
        r_idle <= '0;
      end else if (byte_ready) begin
        if (w_xfer || w_timeout) r_idle <= '0;
        else if (TIMEOUT > 0)    r_idle <= r_idle + 1'b1;
      end
      if (w_xfer) begin
        case (r_state)
          S_LEN_HI:  r_len_hi  <= byte_in;
          S_LEN_LO:  r_len     <= w_len[9:0];
          S_DATA_HI: r_data_hi <= byte_in;
          S_DATA_LO: begin
            r_code <= {r_data_hi, byte_in};
            r_addr <= r_cnt[8:0];
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_cnt <= r_cnt + 10'd1;
    end
  end

endmodule
`default_nettype wire
